// File: rtl/tt_um_lif_neuron.sv
// Leaky integrate-and-fire neuron in the Tiny Tapeout user-module wrapper.
// Shift-based leak, saturating integration, one-cycle spike on uio_out[7].
module tt_um_lif_neuron #(
    parameter logic [7:0] THRESHOLD = 8'd200
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [7:0] state;
    logic       spike;
    logic [2:0] sh;
    logic [7:0] leaked;
    logic [8:0] sum;
    logic [7:0] sat;
    logic       fire;
    logic       unused_uio;

    assign sh     = {1'b0, uio_in[1:0]} + 3'd1;
    assign leaked = state - (state >> sh);
    assign sum    = {1'b0, leaked} + {1'b0, ui_in};
    assign sat    = sum[8] ? 8'hFF : sum[7:0];
    assign fire   = (state >= THRESHOLD);

    assign unused_uio = &{1'b0, uio_in[7:2]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= 8'd0;
            spike <= 1'b0;
        end else if (ena) begin
            // On firing the potential restarts from zero plus this cycle's input
            if (fire) begin
                spike <= 1'b1;
                state <= ui_in;
            end else begin
                spike <= 1'b0;
                state <= sat;
            end
        end
    end

    assign uo_out  = state;
    assign uio_out = {spike, 7'b0};
    assign uio_oe  = 8'h80;

endmodule

// File: tb/tb_tt_um_lif_neuron.sv
// Self-checking bench for tt_um_lif_neuron against an arithmetic LIF model.
// Directed scenarios plus randomized inputs with the model tracking each edge.
module tb_tt_um_lif_neuron;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks;
    int errors;
    int m_state;
    int m_spike;

    tt_um_lif_neuron dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Potential decays to beta*V (rounded up) then adds the current, capped at 255
    function automatic void model_step();
        int div;
        int total;
        if (!ena) return;
        if (m_state >= 200) begin
            m_spike = 1;
            m_state = int'(ui_in);
        end else begin
            div = 1 << (int'(uio_in[1:0]) + 1);
            total = (m_state - m_state / div) + int'(ui_in);
            m_state = (total > 255) ? 255 : total;
            m_spike = 0;
        end
    endfunction

    task automatic clk_step();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_state = 0;
        m_spike = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ena = 1'b1;
        ui_in = 8'd255;
        uio_in = 8'd3;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (uo_out !== 8'd0) begin
            errors++;
            $display("FAIL reset_state: got %0d expected 0", uo_out);
        end
        checks++;
        if (uio_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_uio_out: got %h expected 00", uio_out);
        end
        checks++;
        if (uio_oe !== 8'h80) begin
            errors++;
            $display("FAIL reset_uio_oe: got %h expected 80", uio_oe);
        end
        rst_n = 1'b1;
        m_state = 0;
        m_spike = 0;
    endtask

    task automatic test_integrate_fire();
        int exp_s[10] = '{100, 150, 175, 188, 194, 197, 199, 200, 100, 150};
        int exp_k[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
        ena = 1'b1;
        ui_in = 8'd100;
        uio_in = 8'd0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            clk_step();
            checks++;
            if (uo_out !== 8'(exp_s[i])) begin
                errors++;
                $display("FAIL integrate_state[%0d]: got %0d expected %0d",
                         i, uo_out, exp_s[i]);
            end
            checks++;
            if (uio_out !== {1'(exp_k[i]), 7'b0}) begin
                errors++;
                $display("FAIL integrate_spike[%0d]: got %h expected %0d",
                         i, uio_out, exp_k[i]);
            end
        end
    endtask

    task automatic test_decay();
        int exp_s[9] = '{75, 38, 19, 10, 5, 3, 2, 1, 1};
        int prev;
        ena = 1'b1;
        ui_in = 8'd100;
        uio_in = 8'd0;
        do_reset();
        clk_step();
        clk_step();
        checks++;
        if (uo_out !== 8'd150) begin
            errors++;
            $display("FAIL decay_start: got %0d expected 150", uo_out);
        end
        ui_in = 8'd0;
        prev = 150;
        for (int i = 0; i < 9; i++) begin
            clk_step();
            checks++;
            if (uo_out !== 8'(exp_s[i]) || uio_out !== 8'h00
                || int'(uo_out) > prev) begin
                errors++;
                $display("FAIL decay[%0d]: got %0d/%h expected %0d/00",
                         i, uo_out, uio_out, exp_s[i]);
            end
            prev = int'(uo_out);
        end
    endtask

    task automatic test_leak_select();
        int sel[2] = '{3, 1};
        int exp_s[2] = '{150, 120};
        for (int i = 0; i < 2; i++) begin
            ena = 1'b1;
            ui_in = 8'd160;
            uio_in = 8'd0;
            do_reset();
            clk_step();
            ui_in = 8'd0;
            uio_in = 8'(sel[i]) | 8'hFC;
            clk_step();
            checks++;
            if (uo_out !== 8'(exp_s[i]) || uo_out !== 8'(m_state)) begin
                errors++;
                $display("FAIL leak_sel%0d: got %0d expected %0d",
                         sel[i], uo_out, exp_s[i]);
            end
        end
    endtask

    task automatic test_saturation();
        ena = 1'b1;
        ui_in = 8'd255;
        uio_in = 8'd3;
        do_reset();
        clk_step();
        checks++;
        if (uo_out !== 8'd255 || uio_out !== 8'h00) begin
            errors++;
            $display("FAIL sat_first: got %0d/%h expected 255/00",
                     uo_out, uio_out);
        end
        for (int i = 0; i < 4; i++) begin
            clk_step();
            checks++;
            if (uo_out !== 8'd255 || uio_out !== 8'h80) begin
                errors++;
                $display("FAIL sat_repeat[%0d]: got %0d/%h expected 255/80",
                         i, uo_out, uio_out);
            end
        end
        ui_in = 8'd199;
        uio_in = 8'd0;
        do_reset();
        clk_step();
        ui_in = 8'd255;
        clk_step();
        checks++;
        if (uo_out !== 8'd255 || uio_out !== 8'h00) begin
            errors++;
            $display("FAIL sat_199: got %0d/%h expected 255/00",
                     uo_out, uio_out);
        end
    endtask

    task automatic test_enable_hold();
        logic [7:0] held_s;
        logic [7:0] held_o;
        ena = 1'b1;
        ui_in = 8'd100;
        uio_in = 8'd0;
        do_reset();
        clk_step();
        clk_step();
        clk_step();
        held_s = uo_out;
        held_o = uio_out;
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ui_in = 8'($urandom_range(0, 255));
            clk_step();
            checks++;
            if (uo_out !== held_s || uio_out !== held_o) begin
                errors++;
                $display("FAIL hold[%0d]: got %0d/%h expected %0d/%h",
                         i, uo_out, uio_out, held_s, held_o);
            end
        end
        ena = 1'b1;
        ui_in = 8'd100;
        clk_step();
        checks++;
        if (uo_out !== 8'd188 || uo_out !== 8'(m_state)) begin
            errors++;
            $display("FAIL hold_resume: got %0d expected 188", uo_out);
        end
    endtask

    task automatic test_async_reset();
        ena = 1'b1;
        ui_in = 8'd120;
        uio_in = 8'd1;
        do_reset();
        clk_step();
        clk_step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (uo_out !== 8'd0 || uio_out !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: got %0d/%h expected 0/00",
                     uo_out, uio_out);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_state = 0;
        m_spike = 0;
        clk_step();
        checks++;
        if (uo_out !== 8'd120 || uio_out !== 8'h00) begin
            errors++;
            $display("FAIL async_resume: got %0d/%h expected 120/00",
                     uo_out, uio_out);
        end
    endtask

    task automatic test_random();
        ena = 1'b1;
        ui_in = 8'd0;
        uio_in = 8'd0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            ena = ($urandom_range(0, 9) != 0);
            ui_in = (i % 50 < 25) ? 8'($urandom_range(0, 255))
                                  : 8'($urandom_range(0, 60));
            uio_in = 8'($urandom);
            clk_step();
            checks++;
            if (uo_out !== 8'(m_state)
                || uio_out !== {1'(m_spike), 7'b0}
                || uio_oe !== 8'h80) begin
                errors++;
                $display("FAIL random[%0d]: got %0d/%h/%h expected %0d/%0d/80",
                         i, uo_out, uio_out, uio_oe, m_state, m_spike);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_state = 0;
        m_spike = 0;
        rst_n = 1'b0;
        ena = 1'b0;
        ui_in = 8'd0;
        uio_in = 8'd0;
        test_reset();
        test_integrate_fire();
        test_decay();
        test_leak_select();
        test_saturation();
        test_enable_hold();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
